alu_ctrl_sequencer: RTL and testbench



---
 rtl/alu_ctrl_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer
//
// Sits between instruction decode and the ALU. It accepts one ALU request per
// valid/ready handshake, resolves the full ALU control word from the external
// control word and the active-low mode strobes, and drives it to the ALU as a
// registered control word.
//   - Plain requests (addr_mode_n=1) occupy one EXEC cycle.
//   - Address-mode requests (addr_mode_n=0) occupy ADDR_STEPS cycles: an
//     effective-address add on step 0, then the decoded op on the remaining
//     steps.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  sequencer can accept a request this cycle
//   ctrl_in      in   external ALU control word (used when mov_n=1)
//   mov_n        in   0 = internal operation
//   addr_mode_n  in   0 = address-mode operation
//   incdec_n     in   0 = internal INC/DEC (only with mov_n=0)
//   dec_n        in   0 = DEC, 1 = INC (only with incdec_n=0)
//   alu_ctrl     out  registered ALU control word
//   alu_valid    out  alu_ctrl is a live step
//   step         out  index of the current step
//   busy         out  operation in progress
//   done         out  one-cycle pulse on the final step
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer #(
  parameter int                CTRL_W     = 4,
  parameter int                ADDR_STEPS = 2,
  parameter int                STEP_W     = 3,
  parameter logic [CTRL_W-1:0] CODE_NOP   = 'd0,
  parameter logic [CTRL_W-1:0] CODE_ADD   = 'd1,
  parameter logic [CTRL_W-1:0] CODE_INC   = 'd2,
  parameter logic [CTRL_W-1:0] CODE_DEC   = 'd3,
  parameter logic [CTRL_W-1:0] CODE_MOV   = 'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              mov_n,
  input  logic              addr_mode_n,
  input  logic              incdec_n,
  input  logic              dec_n,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_valid,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);

  // Illegal configurations stop elaboration rather than misbehave silently.
  if (ADDR_STEPS < 2 || ADDR_STEPS > 8) begin : g_bad_addr_steps
    $error("alu_ctrl_sequencer: ADDR_STEPS=%0d outside legal range 2..8", ADDR_STEPS);
  end
  if ((1 << STEP_W) < ADDR_STEPS) begin : g_bad_step_w
    $error("alu_ctrl_sequencer: STEP_W=%0d too narrow for ADDR_STEPS=%0d", STEP_W, ADDR_STEPS);
  end

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ADDR_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ADDR = 2'd2
  } state_t;

  state_t            r_state;
  logic [CTRL_W-1:0] r_op;        // decoded op held for the later ADDR steps
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_alu_valid;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;
  logic              r_done;
  logic              r_out_of_reset; // keeps req_ready low until the first clock after reset

  logic [CTRL_W-1:0] w_op;
  logic              w_last;
  logic              w_accept;

  // Decode of the request currently presented at the inputs.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    w_op = ctrl_in;
    if (!mov_n) begin
      if (incdec_n)   w_op = CODE_MOV;
      else if (dec_n) w_op = CODE_INC;
      else            w_op = CODE_DEC;
    end
  end

  // The final cycle of an operation doubles as an accept slot, which is what
  // lets back-to-back requests run without a bubble.
  assign w_last    = (r_state == S_EXEC) || (r_state == S_ADDR && r_step == LAST_STEP);
  assign req_ready = r_out_of_reset && (r_state == S_IDLE || w_last);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_of_reset <= 1'b0;
    else        r_out_of_reset <= 1'b1;
  end

  // Single FSM block: state and all outputs are registered together, so the
  // ALU never sees a combinational path from the request inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= CODE_NOP;
      r_alu_ctrl  <= CODE_NOP;
      r_alu_valid <= 1'b0;
      r_step      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_accept) begin
      r_op        <= w_op;
      r_alu_valid <= 1'b1;
      r_busy      <= 1'b1;
      r_step      <= '0;
      if (addr_mode_n) begin
        r_state    <= S_EXEC;
        r_alu_ctrl <= w_op;
        r_done     <= 1'b1;
      end else begin
        r_state    <= S_ADDR;
        r_alu_ctrl <= CODE_ADD;
        r_done     <= 1'b0;   // ADDR_STEPS >= 2, so step 0 is never final
      end
    end else if (r_state == S_ADDR && !w_last) begin
      r_alu_ctrl <= r_op;
      r_step     <= r_step + STEP_W'(1);
      r_done     <= (r_step + STEP_W'(1)) == LAST_STEP;
    end else begin
      // Idle, or a final cycle with no follow-on request.
      r_state     <= S_IDLE;
      r_alu_ctrl  <= CODE_NOP;
      r_alu_valid <= 1'b0;
      r_step      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end
  end

  assign alu_ctrl  = r_alu_ctrl;
  assign alu_valid = r_alu_valid;
  assign step      = r_step;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_sequencer
//
// Directed bench for alu_ctrl_sequencer. Two instances share clock and reset:
// dut (ADDR_STEPS=2) and dut5 (ADDR_STEPS=5). Inputs change 1 time unit after
// a rising edge and outputs are sampled at that same point, well away from the
// next edge. Each check compares the packed observation
//   {alu_ctrl[3:0], alu_valid, busy, done, step[2:0], req_ready}
// against a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  // ADDR_STEPS=2 instance
  logic       req_valid, req_ready;
  logic [3:0] ctrl_in;
  logic       mov_n, addr_mode_n, incdec_n, dec_n;
  logic [3:0] alu_ctrl;
  logic       alu_valid, busy, done;
  logic [2:0] step;

  // ADDR_STEPS=5 instance
  logic       b_req_valid, b_req_ready;
  logic [3:0] b_ctrl_in;
  logic       b_mov_n, b_addr_mode_n, b_incdec_n, b_dec_n;
  logic [3:0] b_alu_ctrl;
  logic       b_alu_valid, b_busy, b_done;
  logic [2:0] b_step;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_ctrl_sequencer #(.CTRL_W(4), .ADDR_STEPS(2), .STEP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .ctrl_in(ctrl_in),
    .mov_n(mov_n), .addr_mode_n(addr_mode_n), .incdec_n(incdec_n), .dec_n(dec_n),
    .alu_ctrl(alu_ctrl), .alu_valid(alu_valid), .step(step), .busy(busy), .done(done)
  );

  alu_ctrl_sequencer #(.CTRL_W(4), .ADDR_STEPS(5), .STEP_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .ctrl_in(b_ctrl_in),
    .mov_n(b_mov_n), .addr_mode_n(b_addr_mode_n), .incdec_n(b_incdec_n), .dec_n(b_dec_n),
    .alu_ctrl(b_alu_ctrl), .alu_valid(b_alu_valid), .step(b_step), .busy(b_busy), .done(b_done)
  );

  function automatic logic [10:0] obs();
    return {alu_ctrl, alu_valid, busy, done, step, req_ready};
  endfunction

  function automatic logic [10:0] obs5();
    return {b_alu_ctrl, b_alu_valid, b_busy, b_done, b_step, b_req_ready};
  endfunction

  // Expected-value builder: ctrl, valid, busy, done, step, ready.
  function automatic logic [10:0] ex(input logic [3:0] c, input logic v, input logic b,
                                     input logic d, input logic [2:0] s, input logic r);
    return {c, v, b, d, s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic mv,
                       input logic am, input logic id, input logic dc);
    req_valid = v; ctrl_in = c; mov_n = mv; addr_mode_n = am; incdec_n = id; dec_n = dc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    b_req_valid = 1'b0; b_ctrl_in = 4'h0; b_mov_n = 1'b1;
    b_addr_mode_n = 1'b1; b_incdec_n = 1'b1; b_dec_n = 1'b1;
    #1;
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 0)) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 0));
    end
    tick(); tick();
    rst_n = 1'b1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 0", req_ready);
    end
    tick();
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
      n_fail++; $display("FAIL reset_ready_after_clk: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 1));
    end
  endtask

  task automatic test_passthrough();
    drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (obs() !== ex(4'hA, 1, 1, 1, 3'd0, 1)) begin
      n_fail++; $display("FAIL passthrough_exec: got %h want %h", obs(), ex(4'hA, 1, 1, 1, 3'd0, 1));
    end
    tick();
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
      n_fail++; $display("FAIL passthrough_idle: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 1));
    end
  endtask

  task automatic test_internal_ops();
    // {mov_n, incdec_n, dec_n, expected code}
    logic [6:0] vec [4];
    vec[0] = {1'b0, 1'b1, 1'b1, 4'd4};
    vec[1] = {1'b0, 1'b0, 1'b1, 4'd2};
    vec[2] = {1'b0, 1'b0, 1'b0, 4'd3};
    vec[3] = {1'b0, 1'b1, 1'b0, 4'd4};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'hF, vec[i][6], 1'b1, vec[i][5], vec[i][4]);
      tick();
      drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      n_tests++;
      if (obs() !== ex(vec[i][3:0], 1, 1, 1, 3'd0, 1)) begin
        n_fail++; $display("FAIL internal_op_%0d: got %h want %h", i, obs(), ex(vec[i][3:0], 1, 1, 1, 3'd0, 1));
      end
      tick();
      n_tests++;
      if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
        n_fail++; $display("FAIL internal_op_%0d_idle: got %h want %h", i, obs(), ex(4'h0, 0, 0, 0, 3'd0, 1));
      end
    end
  endtask

  task automatic test_addr_mode();
    drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (obs() !== ex(4'd1, 1, 1, 0, 3'd0, 0)) begin
      n_fail++; $display("FAIL addr_step0: got %h want %h", obs(), ex(4'd1, 1, 1, 0, 3'd0, 0));
    end
    tick();
    n_tests++;
    if (obs() !== ex(4'd3, 1, 1, 1, 3'd1, 1)) begin
      n_fail++; $display("FAIL addr_step1: got %h want %h", obs(), ex(4'd3, 1, 1, 1, 3'd1, 1));
    end
    tick();
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
      n_fail++; $display("FAIL addr_idle: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_seq [4];
    exp_seq[0] = ex(4'h5, 1, 1, 1, 3'd0, 1);
    exp_seq[1] = ex(4'd1, 1, 1, 0, 3'd0, 0);
    exp_seq[2] = ex(4'd3, 1, 1, 1, 3'd1, 1);
    exp_seq[3] = ex(4'h7, 1, 1, 1, 3'd0, 1);
    drive(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1);          // EXEC pass-through 5
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs() !== exp_seq[i]) begin
        n_fail++; $display("FAIL back_to_back_cycle%0d: got %h want %h", i, obs(), exp_seq[i]);
      end
      case (i)
        0: drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);    // ADDR DEC
        1: drive(1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1);    // presented while not ready
        2: drive(1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1);    // accepted on ADDR final cycle
        default: drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      endcase
      tick();
    end
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
      n_fail++; $display("FAIL back_to_back_idle: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 1));
    end
  endtask

  task automatic test_sweep_steps5();
    logic [10:0] expv;
    b_req_valid = 1'b1; b_ctrl_in = 4'hC; b_mov_n = 1'b0;
    b_addr_mode_n = 1'b0; b_incdec_n = 1'b0; b_dec_n = 1'b1;   // address-mode INC
    tick();
    for (int k = 0; k < 5; k++) begin
      expv = ex((k == 0) ? 4'd1 : 4'd2, 1, 1, (k == 4), 3'(k), (k == 4));
      n_tests++;
      if (obs5() !== expv) begin
        n_fail++; $display("FAIL sweep5_step%0d: got %h want %h", k, obs5(), expv);
      end
      if (k < 4) begin
        // Not ready: random request traffic must not disturb the held op.
        b_req_valid   = 1'b1;
        b_ctrl_in     = 4'($urandom);
        b_mov_n       = 1'($urandom);
        b_addr_mode_n = 1'($urandom);
        b_incdec_n    = 1'($urandom);
        b_dec_n       = 1'($urandom);
      end else begin
        b_req_valid = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (obs5() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
      n_fail++; $display("FAIL sweep5_idle: got %h want %h", obs5(), ex(4'h0, 0, 0, 0, 3'd0, 1));
    end
  endtask

  task automatic test_reset_mid_op();
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);          // ADDR MOV
    tick();
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    n_tests++;
    if (obs() !== ex(4'd4, 1, 1, 1, 3'd1, 1)) begin
      n_fail++; $display("FAIL mid_op_pre_reset: got %h want %h", obs(), ex(4'd4, 1, 1, 1, 3'd1, 1));
    end
    #2 rst_n = 1'b0;                                      // between clock edges
    #1;
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 0)) begin
      n_fail++; $display("FAIL mid_op_async_reset: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 0));
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (obs() !== ex(4'h0, 0, 0, 0, 3'd0, 1)) begin
      n_fail++; $display("FAIL mid_op_release: got %h want %h", obs(), ex(4'h0, 0, 0, 0, 3'd0, 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_internal_ops();
    test_addr_mode();
    test_back_to_back();
    test_sweep_steps5();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
